// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard. The open-drain ps2_clk/ps2_data pads
// are driven low through the *_oe outputs. The full sequence is: inhibit, then
// request-to-send, then the 11-bit frame, then the device acknowledge.
// While a transfer is in progress, rx_inhibit tells the shared receiver to
// ignore the bus.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int RTS_CYCLES     = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERR       = 3'd7;

    // Terminal counts; each counter runs from 0 to its terminal value inclusive.
    localparam logic [11:0] INH_LAST = 12'(INHIBIT_CYCLES - 1);
    localparam logic [11:0] RTS_LAST = 12'(RTS_CYCLES - 1);
    localparam logic [18:0] TO_LAST  = 19'(TIMEOUT_CYCLES - 1);
    // The 10th device clock fall places the stop bit; the count is 9 at that fall.
    localparam logic [3:0]  BIT_LAST = 4'd9;

    // Pad synchronizers. They reset to 1, which is the idle (pulled-up) bus level.
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic clk_fall;

    // Two-flop synchronizers on both pads, plus a delayed copy of the clock for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // The fall is built only from registered signals. Because the FSM acts on it
    // at the next edge, data_oe moves 3 cycles after the pad clock falls.
    assign clk_fall = clk_prev_q & ~clk_sync_q;

    logic [2:0]  state_q,   state_d;
    logic [11:0] cnt_q,     cnt_d;
    logic [18:0] to_cnt_q,  to_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  shreg_q,   shreg_d;
    logic        clk_oe_q,  clk_oe_d;
    logic        data_oe_q, data_oe_d;

    // Next-state logic for the transmit sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    // Frame held as {stop, odd parity, data}; it is shifted out LSB first.
                    shreg_d  = {1'b1, ~^tx_data, tx_data};
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;   // start bit; this is the request-to-send
                    state_d   = S_RTS;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    clk_oe_d  = 1'b0;   // hand the clock to the device
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_DATA: begin
                if (to_cnt_q == TO_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 19'd1;
                    if (clk_fall) begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (to_cnt_q == TO_LAST) begin
                    data_oe_d = 1'b0;
                    state_d   = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 19'd1;
                    if (clk_fall) begin
                        state_d = data_sync_q ? S_ERR : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (to_cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 19'd1;
                    if (clk_sync_q && data_sync_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State registers. Asynchronous reset releases both pads immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign rx_inhibit  = (state_q != S_IDLE);
    assign tx_done     = (state_q == S_DONE);
    assign tx_err      = (state_q == S_ERR);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx. The bench includes a simple keyboard model
// that drives the clock and returns the acknowledge on the open-drain bus.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int RTSC = 5;
    localparam int TO   = 3000;
    localparam int LOW  = 20;   // device clock low phase, in system cycles
    localparam int HALF = 10;   // half of the device clock high phase

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, rx_inhibit;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTSC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .rx_inhibit (rx_inhibit),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_clk_release();
        int k;
        k = 0;
        while (ps2_clk_oe !== 1'b0 && k < INH + RTSC + 20) begin
            tick();
            k++;
        end
        check("clk_released", {31'd0, ps2_clk_oe}, 32'd0);
    endtask

    // Keyboard model: clocks in start + 8 data + parity + stop, then acks.
    task automatic device(input bit ack, input bit inject, output logic [10:0] fr);
        fr = '0;
        wait_clk_release();
        repeat (5) tick();
        fr[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            if (inject && i == 4) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
            end
            dev_clk_low = 1'b1;
            repeat (LOW) tick();
            dev_clk_low = 1'b0;
            if (inject && i == 4) begin
                check("ready_busy", {31'd0, tx_ready}, 32'd0);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            repeat (HALF) tick();
            fr[i] = ps2_data_in;
            repeat (HALF) tick();
        end
        if (ack) dev_data_low = 1'b1;
        repeat (5) tick();
        dev_clk_low = 1'b1;
        repeat (LOW) tick();
        dev_clk_low = 1'b0;
        repeat (10) tick();
        dev_data_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic par, input bit ack, input bit inject);
        logic [10:0] fr;
        int dc0, ec0, k;
        dc0 = done_cnt;
        ec0 = err_cnt;
        check("ready_before", {31'd0, tx_ready}, 32'd1);
        accept(b);
        device(ack, inject, fr);
        k = 0;
        while (done_cnt == dc0 && err_cnt == ec0 && k < 500) begin
            tick();
            k++;
        end
        tick();
        check("start_bit", {31'd0, fr[0]}, 32'd0);
        check("data_byte", {24'd0, fr[8:1]}, {24'd0, b});
        check("parity_bit", {31'd0, fr[9]}, {31'd0, par});
        check("stop_bit", {31'd0, fr[10]}, 32'd1);
        check("done_pulses", done_cnt - dc0, ack ? 32'd1 : 32'd0);
        check("err_pulses", err_cnt - ec0, ack ? 32'd0 : 32'd1);
        check("ready_after", {31'd0, tx_ready}, 32'd1);
        $display("[TB] byte %02h frame %011b done=%0d err=%0d", b, fr, done_cnt - dc0, err_cnt - ec0);
    endtask

    initial begin
        int k;
        int ec0, dc0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_err", {31'd0, tx_err}, 32'd0);
        check("rst_inhibit", {31'd0, rx_inhibit}, 32'd0);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_ready", {31'd0, tx_ready}, 32'd1);

        // Inhibit / RTS timing for 0xF4, then the full frame
        dc0 = done_cnt;
        ec0 = err_cnt;
        accept(8'hF4);
        check("acc_ready", {31'd0, tx_ready}, 32'd0);
        check("acc_inhibit", {31'd0, rx_inhibit}, 32'd1);
        check("acc_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        check("acc_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        repeat (INH - 1) tick();
        check("inh_end_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        tick();
        check("rts_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        check("rts_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        repeat (RTSC - 1) tick();
        check("rts_end_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        tick();
        check("release_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        begin
            logic [10:0] fr;
            device(1'b1, 1'b0, fr);
            k = 0;
            while (done_cnt == dc0 && err_cnt == ec0 && k < 500) begin
                tick();
                k++;
            end
            tick();
            check("f4_frame", {21'd0, fr}, {21'd0, 11'b10_1111_0100_0});
            check("f4_done", done_cnt - dc0, 32'd1);
            check("f4_err", err_cnt - ec0, 32'd0);
            check("f4_ready", {31'd0, tx_ready}, 32'd1);
            $display("[TB] byte f4 frame %011b done=%0d err=%0d", fr, done_cnt - dc0, err_cnt - ec0);
        end

        // Parity cases
        send(8'h00, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b1, 1'b0);

        // Device never clocks: timeout exactly TO cycles after clock release
        dc0 = done_cnt;
        ec0 = err_cnt;
        accept(8'h55);
        wait_clk_release();
        k = 0;
        while (tx_err !== 1'b1 && k < TO + 10) begin
            tick();
            k++;
        end
        check("to_latency", k, TO);
        check("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        tick();
        check("to_ready_next", {31'd0, tx_ready}, 32'd1);
        check("to_err_pulses", err_cnt - ec0, 32'd1);
        check("to_done_pulses", done_cnt - dc0, 32'd0);
        $display("[TB] byte 55 timeout after %0d cycles", k);

        // Missing acknowledge
        send(8'h12, 1'b1, 1'b0, 1'b0);

        // tx_valid with 0xAA during DATA is ignored; 0xED completes
        send(8'hED, 1'b1, 1'b1, 1'b1);

        // Reset during INHIBIT
        accept(8'h33);
        repeat (5) tick();
        check("inh_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_inh_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_inh_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_inh_ready", {31'd0, tx_ready}, 32'd1);
        $display("[TB] byte 33 aborted by reset in inhibit");

        // Reset during DATA
        accept(8'hF0);
        wait_clk_release();
        for (int i = 0; i < 2; i++) begin
            dev_clk_low = 1'b1;
            repeat (LOW) tick();
            dev_clk_low = 1'b0;
            repeat (2 * HALF) tick();
        end
        check("data_phase_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_data_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_data_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_data_inhibit", {31'd0, rx_inhibit}, 32'd0);
        $display("[TB] byte f0 aborted by reset in data");

        send(8'hFF, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
